// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the pattern detector and the downstream phase-sequencing FSM.
// Holds the event state encoding and the default pattern constant.
package seq_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } evt_state_t;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage : seq_pkg

// File: rtl/seq_pattern_detector_if.sv
// Serial input and match-event handshake between the detector and its neighbours.
// The slave side is the detector; the master side is the surrounding environment.
interface seq_pattern_detector_if;

  logic x;
  logic x_vld;
  logic evt_valid;
  logic evt_ready;

  modport master (
    output x,
    output x_vld,
    output evt_ready,
    input  evt_valid
  );

  modport slave (
    input  x,
    input  x_vld,
    input  evt_ready,
    output evt_valid
  );

endinterface : seq_pattern_detector_if

// File: rtl/seq_pattern_detector_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shift history, match compare and a one-deep event buffer
// handed to the downstream FSM over a valid/ready handshake, with match/drop counters.
module seq_pattern_detector
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  seq_pattern_detector_if.slave bus,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 overflow
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_reg;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic [FILL_W-1:0] fill_after;
  logic              hit;
  logic              drop;
  logic              overflow_reg;
  evt_state_t        state_reg;
  evt_state_t        state_next;

  // History and fill as they will be once the current bit is shifted in.
  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    if (bus.x_vld) begin
      hist_next = {hist_reg[PAT_W-2:0], bus.x};
      if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + 1'b1;
      end
    end
  end

  assign hit = bus.x_vld & (fill_next == FILL_FULL) & (hist_next == PATTERN);

  // Without overlap a match consumes its bits, so the next one needs a full fresh window.
  assign fill_after = (hit && !OVERLAP) ? '0 : fill_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_after;
    end
  end

  // A new match while one is still unaccepted overwrites it; it only counts as
  // dropped when the downstream is not taking the old one this cycle.
  always_comb begin
    state_next = state_reg;
    drop       = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (hit) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (hit) begin
          drop = ~bus.evt_ready;
        end else if (bus.evt_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (clr) begin
      state_next = EMPTY;
      drop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clr) begin
        overflow_reg <= 1'b0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.evt_valid = (state_reg == PENDING);
  assign overflow      = overflow_reg;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit),
    .cnt   (match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (drop),
    .cnt   (drop_cnt)
  );

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// Three detector instances (overlap, non-overlap, 2-bit counters) share one stimulus stream
// and are compared every cycle against a stream-history model, plus directed literal checks.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic x = 1'b0;
  logic x_vld = 1'b0;
  logic evt_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if bus_ov ();
  seq_pattern_detector_if bus_nov ();
  seq_pattern_detector_if bus_sat ();

  assign bus_ov.x  = x;  assign bus_ov.x_vld  = x_vld; assign bus_ov.evt_ready  = evt_ready;
  assign bus_nov.x = x;  assign bus_nov.x_vld = x_vld; assign bus_nov.evt_ready = evt_ready;
  assign bus_sat.x = x;  assign bus_sat.x_vld = x_vld; assign bus_sat.evt_ready = evt_ready;

  logic [7:0] mc_ov, dc_ov, mc_nov, dc_nov;
  logic [1:0] mc_sat, dc_sat;
  logic       of_ov, of_nov, of_sat;

  seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_ov),
    .match_cnt(mc_ov), .drop_cnt(dc_ov), .overflow(of_ov));

  seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_nov),
    .match_cnt(mc_nov), .drop_cnt(dc_nov), .overflow(of_nov));

  seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_sat),
    .match_cnt(mc_sat), .drop_cnt(dc_sat), .overflow(of_sat));

  // Reference model: every accepted bit since time zero, and per instance the index where
  // its usable history starts (moved by reset, clear and non-overlapping matches).
  localparam int PW = 4;
  bit   stream[$];
  int   start_idx[3];
  bit   ovl[3]  = '{1'b1, 1'b0, 1'b1};
  int   cmax[3] = '{255, 255, 3};
  int   match_m[3];
  int   drop_m[3];
  bit   pend_m[3];
  bit   ovf_m[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int         n;
    logic [3:0] w;
    logic [3:0] pat;
    bit         hit;
    pat = 4'b1011;
    if (!rst_n || clr) begin
      for (int i = 0; i < 3; i++) begin
        start_idx[i] = stream.size();
        match_m[i] = 0; drop_m[i] = 0; pend_m[i] = 1'b0; ovf_m[i] = 1'b0;
      end
      return;
    end
    if (x_vld) stream.push_back(x);
    n = stream.size();
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      if (x_vld && (n - start_idx[i] >= PW)) begin
        for (int k = 0; k < PW; k++) w[PW-1-k] = stream[n-PW+k];
        hit = (w == pat);
      end
      if (hit) begin
        if (pend_m[i] && !evt_ready) begin
          if (drop_m[i] < cmax[i]) drop_m[i]++;
          ovf_m[i] = 1'b1;
        end
        if (match_m[i] < cmax[i]) match_m[i]++;
        if (!ovl[i]) start_idx[i] = n;
        pend_m[i] = 1'b1;
      end else if (pend_m[i] && evt_ready) begin
        pend_m[i] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_idx[i] = 0; match_m[i] = 0; drop_m[i] = 0; pend_m[i] = 1'b0; ovf_m[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk_inst(input int i, input logic ev, input logic [31:0] mc,
                          input logic [31:0] dc, input logic of);
    chk($sformatf("model evt_valid[%0d]", i), {31'd0, ev}, {31'd0, pend_m[i]});
    chk($sformatf("model match_cnt[%0d]", i), mc, match_m[i]);
    chk($sformatf("model drop_cnt[%0d]", i), dc, drop_m[i]);
    chk($sformatf("model overflow[%0d]", i), {31'd0, of}, {31'd0, ovf_m[i]});
  endtask

  // Outputs only move on posedge or rst_n (driven at negedge+1), so negedge is quiet.
  initial begin
    forever begin
      @(negedge clk);
      chk_inst(0, bus_ov.evt_valid, {24'd0, mc_ov}, {24'd0, dc_ov}, of_ov);
      chk_inst(1, bus_nov.evt_valid, {24'd0, mc_nov}, {24'd0, dc_nov}, of_nov);
      chk_inst(2, bus_sat.evt_valid, {30'd0, mc_sat}, {30'd0, dc_sat}, of_sat);
    end
  end

  task automatic drive(input logic xb, input logic vb, input logic rb, input logic cb);
    @(negedge clk);
    #1;
    x = xb; x_vld = vb; evt_ready = rb; clr = cb;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int nb, input logic rb);
    for (int k = nb - 1; k >= 0; k--) drive(bits[k], 1'b1, rb, 1'b0);
  endtask

  initial begin
    logic [6:0] s7;
    logic [6:0] exp_ov;
    logic [6:0] exp_nov;
    s7      = 7'b1011011;
    exp_ov  = 7'b0001001;
    exp_nov = 7'b0001000;

    // Reset state and async reset mid-event
    repeat (3) @(negedge clk);
    #1;
    chk("reset evt_valid", {31'd0, bus_ov.evt_valid}, 32'd0);
    chk("reset match_cnt", {24'd0, mc_ov}, 32'd0);
    chk("reset overflow", {31'd0, of_ov}, 32'd0);
    rst_n = 1'b1;
    send_bits(16'b1011, 4, 1'b0);
    after_edge();
    chk("pre-reset evt_valid", {31'd0, bus_ov.evt_valid}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset evt_valid", {31'd0, bus_ov.evt_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    send_bits(16'b011, 3, 1'b1);
    after_edge();
    chk("post-reset no early hit", {31'd0, bus_ov.evt_valid}, 32'd0);
    chk("post-reset match_cnt", {24'd0, mc_ov}, 32'd0);
    chk("post-reset drop_cnt", {24'd0, dc_ov}, 32'd0);
    send_bits(16'b011, 3, 1'b1);
    after_edge();
    chk("post-reset fresh hit", {31'd0, bus_ov.evt_valid}, 32'd1);

    // Overlap vs non-overlap on 1011011
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 6; k >= 0; k--) begin
      drive(s7[k], 1'b1, 1'b1, 1'b0);
      after_edge();
      chk($sformatf("overlap evt bit%0d", 7 - k), {31'd0, bus_ov.evt_valid}, {31'd0, exp_ov[k]});
      chk($sformatf("nonovl evt bit%0d", 7 - k), {31'd0, bus_nov.evt_valid}, {31'd0, exp_nov[k]});
    end
    chk("overlap match_cnt", {24'd0, mc_ov}, 32'd2);
    chk("nonovl match_cnt", {24'd0, mc_nov}, 32'd1);

    // Backpressure
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(16'b1011011, 7, 1'b0);
    after_edge();
    chk("bp evt held", {31'd0, bus_ov.evt_valid}, 32'd1);
    chk("bp drop_cnt", {24'd0, dc_ov}, 32'd1);
    chk("bp overflow", {31'd0, of_ov}, 32'd1);
    chk("bp match_cnt", {24'd0, mc_ov}, 32'd2);
    chk("bp nonovl drop_cnt", {24'd0, dc_nov}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp evt before accept edge", {31'd0, bus_ov.evt_valid}, 32'd1);
    after_edge();
    chk("bp evt after accept", {31'd0, bus_ov.evt_valid}, 32'd0);
    chk("bp overflow sticky", {31'd0, of_ov}, 32'd1);

    // Gaps, then clear on the last pattern bit
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("gap evt", {31'd0, bus_ov.evt_valid}, 32'd1);
    chk("gap match_cnt", {24'd0, mc_ov}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(16'b101, 3, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    after_edge();
    chk("clr-hit evt", {31'd0, bus_ov.evt_valid}, 32'd0);
    chk("clr-hit match_cnt", {24'd0, mc_ov}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("clr-hit evt later", {31'd0, bus_ov.evt_valid}, 32'd0);

    // Saturation of the 2-bit counter
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(16'b1011011011011011, 16, 1'b1);
    after_edge();
    chk("sat match_cnt", {30'd0, mc_sat}, 32'd3);
    chk("wide match_cnt", {24'd0, mc_ov}, 32'd5);
    send_bits(16'b011, 3, 1'b1);
    after_edge();
    chk("sat match_cnt holds", {30'd0, mc_sat}, 32'd3);
    chk("wide match_cnt 6", {24'd0, mc_ov}, 32'd6);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
      rst_n = ($urandom_range(0, 299) != 0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_detector
